// File: rtl/sram_req_arbiter.sv
// Two-master to one-slave SRAM-style arbiter; m1 (data) has priority, m0 (fetch) has anti-starvation.
// Latency: 0 cycles on both address and response paths (pure combinational pass-through).
// Backpressure: s_addr_ok stalls the granted master; s_req drops while DEPTH requests are outstanding.
module sram_req_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  output logic        err_orphan
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {UNLOCKED, LOCKED} lock_t;

  lock_t          state, state_nxt;
  logic           gsel;
  logic [SW-1:0]  starve_cnt;
  logic           owner_q [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;

  logic grant_m1, grant_vld, granted_req, full, accept, pop, head_m1;

  // Grant: locked grant is frozen in gsel until the slave takes the address.
  always_comb begin
    grant_m1  = 1'b0;
    grant_vld = 1'b0;
    if (state == LOCKED) begin
      grant_m1  = gsel;
      grant_vld = 1'b1;
    end else if (m1_req && !(m0_req && starve_cnt == STARVE_MAX)) begin
      grant_m1  = 1'b1;
      grant_vld = 1'b1;
    end else if (m0_req) begin
      grant_vld = 1'b1;
    end
  end

  assign granted_req = grant_vld && (grant_m1 ? m1_req : m0_req);
  assign full        = (count == FULL_CNT);
  assign s_req       = !reset && granted_req && !full;
  assign accept      = s_req && s_addr_ok;
  assign pop         = !reset && s_data_ok && (count != '0);
  assign head_m1     = owner_q[rd_ptr];

  assign s_wr    = grant_m1 ? m1_wr    : m0_wr;
  assign s_size  = grant_m1 ? m1_size  : m0_size;
  assign s_wstrb = grant_m1 ? m1_wstrb : m0_wstrb;
  assign s_addr  = grant_m1 ? m1_addr  : m0_addr;
  assign s_wdata = grant_m1 ? m1_wdata : m0_wdata;

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  // Lock FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= UNLOCKED;
      gsel  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == UNLOCKED && s_req && !s_addr_ok)
        gsel <= grant_m1;
    end
  end

  // Lock FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      UNLOCKED: if (s_req && !s_addr_ok) state_nxt = LOCKED;
      LOCKED:   if (s_addr_ok)           state_nxt = UNLOCKED;
      default:  state_nxt = UNLOCKED;
    endcase
  end

  // Lock FSM: outputs
  always_comb begin
    m0_addr_ok = accept && !grant_m1;
    m1_addr_ok = accept &&  grant_m1;
    m0_data_ok = pop && !head_m1;
    m1_data_ok = pop &&  head_m1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (accept) begin
        owner_q[wr_ptr] <= grant_m1;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (s_data_ok && count == '0)
        err_orphan <= 1'b1;
      // Counter only tracks m1 wins that actually kept a waiting m0 out.
      if (!m0_req)
        starve_cnt <= '0;
      else if (accept && !grant_m1)
        starve_cnt <= '0;
      else if (accept && grant_m1 && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: stimulus queues expected grants/responses, a negedge monitor compares.
module tb_sram_req_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr;
  logic [1:0]  m0_size;
  logic [3:0]  m0_wstrb;
  logic [31:0] m0_addr, m0_wdata;
  logic        m0_addr_ok, m0_data_ok;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_wr;
  logic [1:0]  m1_size;
  logic [3:0]  m1_wstrb;
  logic [31:0] m1_addr, m1_wdata;
  logic        m1_addr_ok, m1_data_ok;
  logic [31:0] m1_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;
  logic        err_orphan;

  int n_checks = 0;
  int n_pass   = 0;
  logic [73:0] exp_acc_q [$];
  logic [33:0] exp_rsp_q [$];

  always #5 clk = ~clk;

  sram_req_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_wstrb(m0_wstrb),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
    .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_wstrb(m1_wstrb),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
    .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
    .s_data_ok(s_data_ok), .s_rdata(s_rdata), .err_orphan(err_orphan)
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected accept word: {m0_addr_ok, m1_addr_ok, s_wr, s_size, s_wstrb, s_wdata, s_addr}
  function automatic logic [73:0] acc_word(input logic owner, input logic wr, input logic [31:0] addr);
    logic [1:0] sz;
    logic [3:0] st;
    sz = wr ? 2'd1 : 2'd2;
    st = wr ? 4'h3 : 4'hf;
    return {~owner, owner, wr, sz, st, ~addr, addr};
  endfunction

  task automatic push_acc(input logic owner, input logic wr, input logic [31:0] addr);
    exp_acc_q.push_back(acc_word(owner, wr, addr));
  endtask

  task automatic push_rsp(input logic owner, input logic [31:0] data);
    s_data_ok = 1'b1;
    s_rdata   = data;
    exp_rsp_q.push_back({~owner, owner, data});
  endtask

  task automatic drive_m0(input logic req, input logic [31:0] addr);
    m0_req = req; m0_wr = 1'b0; m0_size = 2'd2; m0_wstrb = 4'hf;
    m0_addr = addr; m0_wdata = ~addr;
  endtask

  task automatic drive_m1(input logic req, input logic wr, input logic [31:0] addr);
    m1_req = req; m1_wr = wr; m1_size = wr ? 2'd1 : 2'd2; m1_wstrb = wr ? 4'h3 : 4'hf;
    m1_addr = addr; m1_wdata = ~addr;
  endtask

  task automatic idle();
    m0_req = 1'b0; m1_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every addr_ok/data_ok the DUT raises must match the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (m0_addr_ok || m1_addr_ok) begin
        if (exp_acc_q.size() == 0)
          check("acc_unexpected", {m0_addr_ok, m1_addr_ok, s_wr, s_size, s_wstrb, s_wdata, s_addr}, 80'h0);
        else
          check("acc", {m0_addr_ok, m1_addr_ok, s_wr, s_size, s_wstrb, s_wdata, s_addr}, exp_acc_q.pop_front());
      end
      if (m0_data_ok || m1_data_ok) begin
        if (exp_rsp_q.size() == 0)
          check("rsp_unexpected", {m0_data_ok, m1_data_ok, (m1_data_ok ? m1_rdata : m0_rdata)}, 80'h0);
        else
          check("rsp", {m0_data_ok, m1_data_ok, (m1_data_ok ? m1_rdata : m0_rdata)}, exp_rsp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle();
    drive_m0(1'b1, 32'h0000_0100);
    drive_m1(1'b1, 1'b1, 32'h0000_0200);
    s_addr_ok = 1'b1;
    s_data_ok = 1'b1;
    step();
    step();
    #3 check("reset_outputs", {s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok}, 80'h0);
    step(); reset = 1'b0; idle();
    #3 check("reset_err_orphan", err_orphan, 80'h0);
    check("reset_idle_sreq", s_req, 80'h0);

    // Lone m0 read, response two cycles later
    step(); drive_m0(1'b1, 32'h1c00_0000); s_addr_ok = 1'b1; push_acc(1'b0, 1'b0, 32'h1c00_0000);
    step(); idle();
    step(); push_rsp(1'b0, 32'h1234_5678);
    step(); idle();

    // Contention: m1 first, m0 after m1 drops
    step(); drive_m0(1'b1, 32'h0000_1000); drive_m1(1'b1, 1'b1, 32'h0000_2000); s_addr_ok = 1'b1;
    push_acc(1'b1, 1'b1, 32'h0000_2000);
    step(); m1_req = 1'b0; push_acc(1'b0, 1'b0, 32'h0000_1000);
    step(); idle(); push_rsp(1'b1, 32'hd1d1_0001);
    step(); idle(); push_rsp(1'b0, 32'hd0d0_0002);

    // Lock: m0 held for 3 stall cycles while m1 arrives
    step(); idle(); drive_m0(1'b1, 32'h0000_3000);
    #3 check("lock_c0_addr", s_addr, 32'h0000_3000);
    step(); drive_m1(1'b1, 1'b0, 32'h0000_4000);
    #3 check("lock_c1_addr", s_addr, 32'h0000_3000);
    step();
    #3 check("lock_c2_addr", s_addr, 32'h0000_3000);
    step(); s_addr_ok = 1'b1; push_acc(1'b0, 1'b0, 32'h0000_3000);
    #3 check("lock_c3_addr", s_addr, 32'h0000_3000);
    step(); m0_req = 1'b0; push_acc(1'b1, 1'b0, 32'h0000_4000);
    step(); idle(); push_rsp(1'b0, 32'h3333_0000);
    step(); idle(); push_rsp(1'b1, 32'h4444_0000);

    // Full and ordering: m1,m0,m1,m0 outstanding
    step(); idle(); s_addr_ok = 1'b1; drive_m1(1'b1, 1'b1, 32'h0000_e000); push_acc(1'b1, 1'b1, 32'h0000_e000);
    step(); m1_req = 1'b0; drive_m0(1'b1, 32'h0000_e100); push_acc(1'b0, 1'b0, 32'h0000_e100);
    step(); m0_req = 1'b0; drive_m1(1'b1, 1'b0, 32'h0000_e200); push_acc(1'b1, 1'b0, 32'h0000_e200);
    step(); m1_req = 1'b0; drive_m0(1'b1, 32'h0000_e300); push_acc(1'b0, 1'b0, 32'h0000_e300);
    step(); drive_m0(1'b1, 32'h0000_e400);
    #3 check("full_sreq", s_req, 80'h0);
    step(); push_rsp(1'b1, 32'hf000_0000);
    #3 check("full_pop_sreq", s_req, 80'h0);
    step(); idle(); push_rsp(1'b0, 32'hf000_0001);
    step(); idle(); push_rsp(1'b1, 32'hf000_0002);
    step(); idle(); push_rsp(1'b0, 32'hf000_0003);

    // Starvation: 8 m1 wins, then one forced m0, then m1 again
    for (int i = 0; i < 10; i++) begin
      step(); idle();
      drive_m0(1'b1, 32'h0000_d000); drive_m1(1'b1, 1'b0, 32'h0000_d100); s_addr_ok = 1'b1;
      if (i == 8) push_acc(1'b0, 1'b0, 32'h0000_d000);
      else        push_acc(1'b1, 1'b0, 32'h0000_d100);
      if (i > 0) push_rsp((i - 1 == 8) ? 1'b0 : 1'b1, 32'ha000_0000 + 32'(i - 1));
    end
    step(); idle(); push_rsp(1'b1, 32'ha000_0009);

    // Orphan response
    step(); idle(); s_data_ok = 1'b1;
    step(); idle();
    #3 check("orphan_err", err_orphan, 80'h1);

    // Reset with two requests outstanding
    step(); s_addr_ok = 1'b1; drive_m1(1'b1, 1'b0, 32'h0000_f000); push_acc(1'b1, 1'b0, 32'h0000_f000);
    step(); m1_req = 1'b0; drive_m0(1'b1, 32'h0000_f100); push_acc(1'b0, 1'b0, 32'h0000_f100);
    step(); reset = 1'b1; m1_req = 1'b1; s_data_ok = 1'b1;
    #3 check("rst2_outputs_a", {s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok}, 80'h0);
    step();
    #3 check("rst2_outputs_b", {s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok}, 80'h0);
    step(); reset = 1'b0; idle();
    #3 check("rst2_err_cleared", err_orphan, 80'h0);
    step(); s_data_ok = 1'b1;
    step(); idle();
    #3 check("rst2_fifo_empty", err_orphan, 80'h1);
    step();

    check("acc_queue_drained", exp_acc_q.size(), 80'h0);
    check("rsp_queue_drained", exp_rsp_q.size(), 80'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
